// File: rtl/core_reset_quiescer_pkg.sv
// Shared types for the core warm-reset quiescer.
// State encoding and AXI port indices.
package core_reset_quiescer_pkg;

  typedef enum logic [1:0] {
    S_RESET,
    S_RELEASE,
    S_IDLE,
    S_DRAIN
  } state_e;

  localparam int unsigned NPORT     = 2;
  localparam int unsigned PORT_MEM  = 0;
  localparam int unsigned PORT_MMIO = 1;

endpackage

// File: rtl/core_reset_quiescer_if.sv
// Snooped AXI handshake wires and the per-channel issue gates.
// The quiescer is the slave: it watches the bus and drives the gates.
interface core_reset_quiescer_if;
  import core_reset_quiescer_pkg::*;

  logic [NPORT-1:0] aw_valid;
  logic [NPORT-1:0] aw_ready;
  logic [NPORT-1:0] ar_valid;
  logic [NPORT-1:0] ar_ready;
  logic [NPORT-1:0] b_valid;
  logic [NPORT-1:0] b_ready;
  logic [NPORT-1:0] r_valid;
  logic [NPORT-1:0] r_ready;
  logic [NPORT-1:0] r_last;
  logic [NPORT-1:0] aw_gate;
  logic [NPORT-1:0] ar_gate;

  modport master (
    output aw_valid, aw_ready,
    output ar_valid, ar_ready,
    output b_valid, b_ready,
    output r_valid, r_ready, r_last,
    input  aw_gate, ar_gate
  );

  modport slave (
    input  aw_valid, aw_ready,
    input  ar_valid, ar_ready,
    input  b_valid, b_ready,
    input  r_valid, r_ready, r_last,
    output aw_gate, ar_gate
  );

endinterface

// File: rtl/core_reset_quiescer_counter.sv
// Saturating outstanding-transaction counter.
// Balanced inc/dec holds; dec at zero and inc at max are dropped.
module outstanding_counter #(
  parameter int unsigned OUT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             clr_i,
  output logic [OUT_W-1:0] cnt_o
);

  localparam logic [OUT_W-1:0] MAX = '1;

  logic [OUT_W-1:0] cnt_q;
  logic [OUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:
        cnt_d = '0;
      !clr_i && inc_i && !dec_i && (cnt_q != MAX):
        cnt_d = cnt_q + OUT_W'(1);
      !clr_i && dec_i && !inc_i && (cnt_q != '0):
        cnt_d = cnt_q - OUT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_reset_quiescer.sv
// Fences AXI issue, drains in-flight bursts, then pulses core reset.
// All outputs come straight from registers.
module core_reset_quiescer
  import core_reset_quiescer_pkg::*;
#(
  parameter int unsigned OUT_W          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned RESET_CYCLES   = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rst_req,
  core_reset_quiescer_if.slave bus,
  output logic                 core_reset,
  output logic                 busy,
  output logic                 timed_out
);

  localparam int unsigned TMAX =
    (TIMEOUT_CYCLES > RESET_CYCLES) ? TIMEOUT_CYCLES : RESET_CYCLES;
  localparam int unsigned TW = $clog2(TMAX + 1);

  state_e           state_q;
  logic [TW-1:0]    tmr_q;
  logic [NPORT-1:0] aw_gate_q;
  logic [NPORT-1:0] ar_gate_q;
  logic             core_reset_q;
  logic             busy_q;
  logic             timed_out_q;

  logic [OUT_W-1:0] wr_cnt [NPORT];
  logic [OUT_W-1:0] rd_cnt [NPORT];
  logic [NPORT-1:0] cnt_zero;
  logic             clr;
  logic             drained;
  logic [NPORT-1:0] aw_fence;
  logic [NPORT-1:0] ar_fence;

  assign clr = (state_q == S_RESET);

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    outstanding_counter #(.OUT_W(OUT_W)) u_wr (
      .clk_i (clock),
      .rst_i (reset),
      .inc_i (bus.aw_valid[i] & bus.aw_ready[i] & ~aw_gate_q[i]),
      .dec_i (bus.b_valid[i] & bus.b_ready[i]),
      .clr_i (clr),
      .cnt_o (wr_cnt[i])
    );
    outstanding_counter #(.OUT_W(OUT_W)) u_rd (
      .clk_i (clock),
      .rst_i (reset),
      .inc_i (bus.ar_valid[i] & bus.ar_ready[i] & ~ar_gate_q[i]),
      .dec_i (bus.r_valid[i] & bus.r_ready[i] & bus.r_last[i]),
      .clr_i (clr),
      .cnt_o (rd_cnt[i])
    );
    assign cnt_zero[i] = (wr_cnt[i] == '0) && (rd_cnt[i] == '0);
  end

  // A channel may only close when no valid is stalled waiting for ready.
  assign aw_fence = aw_gate_q | ~(bus.aw_valid & ~bus.aw_ready);
  assign ar_fence = ar_gate_q | ~(bus.ar_valid & ~bus.ar_ready);
  assign drained  = (&aw_gate_q) & (&ar_gate_q) & (&cnt_zero);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_RESET;
      tmr_q        <= '0;
      aw_gate_q    <= '1;
      ar_gate_q    <= '1;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b1;
      timed_out_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_RESET: begin
          if (tmr_q == TW'(RESET_CYCLES - 1)) begin
            state_q      <= S_RELEASE;
            tmr_q        <= '0;
            core_reset_q <= 1'b0;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        S_RELEASE: begin
          state_q   <= S_IDLE;
          aw_gate_q <= '0;
          ar_gate_q <= '0;
          busy_q    <= 1'b0;
        end
        S_IDLE: begin
          if (rst_req) begin
            state_q     <= S_DRAIN;
            tmr_q       <= '0;
            busy_q      <= 1'b1;
            timed_out_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state_q      <= S_RESET;
            tmr_q        <= '0;
            core_reset_q <= 1'b1;
          end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= S_RESET;
            tmr_q        <= '0;
            core_reset_q <= 1'b1;
            aw_gate_q    <= '1;
            ar_gate_q    <= '1;
            timed_out_q  <= 1'b1;
          end else begin
            tmr_q     <= tmr_q + TW'(1);
            aw_gate_q <= aw_fence;
            ar_gate_q <= ar_fence;
          end
        end
        default: state_q <= S_RESET;
      endcase
    end
  end

  assign bus.aw_gate = aw_gate_q;
  assign bus.ar_gate = ar_gate_q;
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign timed_out   = timed_out_q;

endmodule

// File: tb/tb_core_reset_quiescer.sv
// Bench for core_reset_quiescer: directed scenarios plus random
// traffic, all checked cycle by cycle against a timeline model.
module tb_core_reset_quiescer;
  import core_reset_quiescer_pkg::*;

  localparam int RC   = 16;
  localparam int TO   = 1024;
  localparam int CMAX = 15;
  localparam logic [1:0] MEM  = 2'(1 << PORT_MEM);
  localparam logic [1:0] MMIO = 2'(1 << PORT_MMIO);

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic rst_req = 1'b0;
  logic core_reset, busy, timed_out;

  core_reset_quiescer_if bus();

  core_reset_quiescer #(
    .OUT_W(4), .TIMEOUT_CYCLES(TO), .RESET_CYCLES(RC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rst_req    (rst_req),
    .bus        (bus),
    .core_reset (core_reset),
    .busy       (busy),
    .timed_out  (timed_out)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Model: a reset run starts at cycle rs; a drain starts at ds.
  int cyc, rs, ds;
  bit drn, mto;
  bit [1:0] mgw, mgr;
  int wc[2], rc[2];

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               tag, got, exp, cyc);
    end
  endtask

  // 0 reset pulse, 1 release, 2 idle, 3 drain
  function automatic int ph();
    if (drn) return 3;
    if (cyc - rs < RC) return 0;
    if (cyc - rs == RC) return 1;
    return 2;
  endfunction

  function automatic logic [1:0] e_gate(bit wr);
    case (ph())
      0, 1:    return 2'b11;
      3:       return wr ? mgw : mgr;
      default: return 2'b00;
    endcase
  endfunction

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > CMAX) return CMAX;
    return v;
  endfunction

  task automatic model_step();
    int p;
    logic [1:0] ew, er;
    bit quiet;
    p = ph();
    ew = e_gate(1'b1);
    er = e_gate(1'b0);
    quiet = 1'b1;
    for (int i = 0; i < 2; i++)
      if (wc[i] != 0 || rc[i] != 0) quiet = 1'b0;
    if (p == 2 && rst_req) begin
      drn = 1; ds = cyc + 1; mto = 0; mgw = 0; mgr = 0;
    end else if (p == 3) begin
      if (mgw == 2'b11 && mgr == 2'b11 && quiet) begin
        drn = 0; rs = cyc + 1;
      end else if (cyc + 1 - ds == TO) begin
        drn = 0; rs = cyc + 1; mto = 1;
      end else begin
        mgw |= ~(bus.aw_valid & ~bus.aw_ready);
        mgr |= ~(bus.ar_valid & ~bus.ar_ready);
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (p == 0) begin
        wc[i] = 0; rc[i] = 0;
      end else begin
        wc[i] = clamp(wc[i]
          + int'(bus.aw_valid[i] & bus.aw_ready[i] & ~ew[i])
          - int'(bus.b_valid[i] & bus.b_ready[i]));
        rc[i] = clamp(rc[i]
          + int'(bus.ar_valid[i] & bus.ar_ready[i] & ~er[i])
          - int'(bus.r_valid[i] & bus.r_ready[i] & bus.r_last[i]));
      end
    end
  endtask

  task automatic step();
    chk("m_cr", 32'(core_reset), 32'(ph() == 0));
    chk("m_busy", 32'(busy), 32'(ph() != 2));
    chk("m_awg", 32'(bus.aw_gate), 32'(e_gate(1'b1)));
    chk("m_arg", 32'(bus.ar_gate), 32'(e_gate(1'b0)));
    chk("m_to", 32'(timed_out), 32'(mto));
    model_step();
    @(negedge clock);
    cyc++;
  endtask

  task automatic clr_in();
    rst_req = 0;
    bus.aw_valid = '0; bus.aw_ready = '0;
    bus.ar_valid = '0; bus.ar_ready = '0;
    bus.b_valid  = '0; bus.b_ready  = '0;
    bus.r_valid  = '0; bus.r_ready  = '0;
    bus.r_last   = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clr_in();
    repeat (2) @(negedge clock);
    chk("rst_cr", 32'(core_reset), 32'(1));
    chk("rst_aw", 32'(bus.aw_gate), 32'(2'b11));
    chk("rst_ar", 32'(bus.ar_gate), 32'(2'b11));
    chk("rst_busy", 32'(busy), 32'(1));
    chk("rst_to", 32'(timed_out), 32'(0));
    reset = 1'b0;
    cyc = 0; rs = 0; drn = 0; mto = 0;
    for (int i = 0; i < 2; i++) begin wc[i] = 0; rc[i] = 0; end
  endtask

  task automatic run_to(int t);
    while (cyc < t) step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 64) begin step(); n++; end
    chk("idle_reached", 32'(busy), 32'(0));
  endtask

  task automatic req(output int t);
    rst_req = 1; t = cyc; step(); rst_req = 0;
  endtask

  task automatic aw_f(logic [1:0] m);
    bus.aw_valid = m; bus.aw_ready = m; step(); clr_in();
  endtask
  task automatic ar_f(logic [1:0] m);
    bus.ar_valid = m; bus.ar_ready = m; step(); clr_in();
  endtask
  task automatic b_f(logic [1:0] m);
    bus.b_valid = m; bus.b_ready = m; step(); clr_in();
  endtask
  task automatic r_f(logic [1:0] m);
    bus.r_valid = m; bus.r_ready = m; bus.r_last = m;
    step(); clr_in();
  endtask

  initial begin
    int t;
    apply_reset();

    // power-on sequence
    for (int i = 0; i <= 17; i++) begin
      chk("por_cr", 32'(core_reset), 32'(i < 16));
      chk("por_aw", 32'(bus.aw_gate), 32'(i < 17 ? 2'b11 : 2'b00));
      chk("por_busy", 32'(busy), 32'(i < 17));
      step();
    end

    // quiet bus
    run_to(100);
    req(t);
    chk("q_busy", 32'(busy), 32'(1));
    chk("q_gate0", 32'(bus.aw_gate), 32'(0));
    step();
    chk("q_gate", 32'({bus.aw_gate, bus.ar_gate}), 32'(4'hf));
    step();
    chk("q_cr_on", 32'(core_reset), 32'(1));
    run_to(t + 18);
    chk("q_cr_last", 32'(core_reset), 32'(1));
    step();
    chk("q_cr_off", 32'(core_reset), 32'(0));
    chk("q_rel_g", 32'(bus.ar_gate), 32'(2'b11));
    step();
    chk("q_open", 32'({bus.aw_gate, bus.ar_gate}), 32'(0));
    chk("q_idle", 32'(busy), 32'(0));
    chk("q_to", 32'(timed_out), 32'(0));

    // drain with two reads in flight
    ar_f(MEM); ar_f(MEM);
    req(t);
    run_to(t + 6);
    chk("rd2_hold", 32'(core_reset), 32'(0));
    r_f(MEM);
    run_to(cyc + 4);
    chk("rd1_hold", 32'(core_reset), 32'(0));
    r_f(MEM);
    chk("rd0_p1", 32'(core_reset), 32'(0));
    step();
    chk("rd0_p2", 32'(core_reset), 32'(1));
    wait_idle();

    // fence during held AW handshake on MMIO
    bus.aw_valid = MMIO;
    req(t);
    bus.aw_valid = MMIO;
    run_to(t + 2);
    chk("fen_aw", 32'(bus.aw_gate), 32'(2'b01));
    chk("fen_ar", 32'(bus.ar_gate), 32'(2'b11));
    run_to(t + 5);
    chk("fen_held", 32'(bus.aw_gate), 32'(2'b01));
    bus.aw_ready = MMIO;
    step();
    clr_in();
    chk("fen_set", 32'(bus.aw_gate), 32'(2'b11));
    run_to(cyc + 5);
    chk("fen_wr1", 32'(core_reset), 32'(0));
    b_f(MMIO);
    chk("fen_b1", 32'(core_reset), 32'(0));
    step();
    chk("fen_b2", 32'(core_reset), 32'(1));
    wait_idle();

    // timeout with an unanswered write
    aw_f(MEM);
    req(t);
    run_to(t + TO);
    chk("tmo_pre_cr", 32'(core_reset), 32'(0));
    chk("tmo_pre_to", 32'(timed_out), 32'(0));
    step();
    chk("tmo_cr", 32'(core_reset), 32'(1));
    chk("tmo_flag", 32'(timed_out), 32'(1));
    wait_idle();
    chk("tmo_sticky", 32'(timed_out), 32'(1));
    req(t);
    chk("tmo_clr", 32'(timed_out), 32'(0));
    wait_idle();

    // simultaneous inc/dec at 3
    aw_f(MEM); aw_f(MEM); aw_f(MEM);
    bus.aw_valid = MEM; bus.aw_ready = MEM;
    bus.b_valid = MEM; bus.b_ready = MEM;
    step(); clr_in();
    b_f(MEM); b_f(MEM);
    req(t);
    run_to(t + 6);
    chk("sim_hold", 32'(core_reset), 32'(0));
    b_f(MEM);
    step();
    chk("sim_done", 32'(core_reset), 32'(1));
    wait_idle();

    // decrement at zero
    b_f(MEM); b_f(MEM);
    aw_f(MEM);
    req(t);
    run_to(t + 6);
    chk("udf_hold", 32'(core_reset), 32'(0));
    b_f(MEM);
    step();
    chk("udf_done", 32'(core_reset), 32'(1));
    wait_idle();

    // saturation at 15
    for (int i = 0; i < 16; i++) ar_f(MEM);
    req(t);
    for (int i = 0; i < 14; i++) r_f(MEM);
    step(); step();
    chk("sat_hold", 32'(core_reset), 32'(0));
    r_f(MEM);
    step();
    chk("sat_done", 32'(core_reset), 32'(1));
    wait_idle();

    // rst_req held while busy is ignored
    req(t);
    rst_req = 1;
    run_to(t + 19);
    rst_req = 0;
    step();
    chk("ign_idle", 32'(busy), 32'(0));
    step();
    chk("ign_stay", 32'(busy), 32'(0));

    // reset during drain
    aw_f(MEM);
    req(t);
    run_to(t + 10);
    chk("rd_busy", 32'(busy), 32'(1));
    apply_reset();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      bus.aw_valid = 2'($urandom); bus.aw_ready = 2'($urandom);
      bus.ar_valid = 2'($urandom); bus.ar_ready = 2'($urandom);
      bus.b_valid  = 2'($urandom); bus.b_ready  = 2'($urandom);
      bus.r_valid  = 2'($urandom); bus.r_ready  = 2'($urandom);
      bus.r_last   = 2'($urandom);
      rst_req = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 999) == 0) apply_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
